// File: rtl/game_pkg.sv
// Shared types and defaults for the game-flow controller.
package game_pkg;

  // Screen owned by the VGA pipeline; the encoding is also the mux select.
  typedef enum logic [1:0] {
    START = 2'd0,
    SHOOT = 2'd1,
    WIN   = 2'd2,
    LOSE  = 2'd3
  } game_state_t;

  localparam int DEF_WIN_GOALS  = 3;
  localparam int DEF_MAX_MISSES = 3;

  // Score counters are 3 bits wide and stop at their top value.
  localparam logic [2:0] SCORE_MAX = 3'd7;

  // Saturating increment for the score counters.
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == SCORE_MAX) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/screen_ctl_edge_det.sv
// Registered rising-edge detector: din is compared against its copy from
// the previous cycle, so rise is high for the single cycle din first reads 1.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Keep last cycle's sample of din.
  // NOTE: sequential state is always written with <=, so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/screen_ctl.sv
// Game-flow controller. next_screen holds the decided screen and reacts to
// events at once; screen is what the VGA pipeline shows and only loads
// next_screen on a vblnk rising edge, so a frame never switches renderer.
module screen_ctl
  import game_pkg::*;
#(
  parameter int WIN_GOALS       = DEF_WIN_GOALS,
  parameter int MAX_MISSES      = DEF_MAX_MISSES,
  parameter int END_HOLD_FRAMES = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        start_btn,
  input  logic        goal,
  input  logic        miss,
  output game_state_t screen,
  output logic [2:0]  goals,
  output logic [2:0]  misses,
  output logic        frame_tick
);

  localparam int HOLD_W = $clog2(END_HOLD_FRAMES + 1);

  game_state_t       next_screen;
  game_state_t       next_screen_d;
  logic [2:0]        goals_d;
  logic [2:0]        misses_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_d;
  logic              vblnk_rise;
  logic              start_rise;
  logic              accept;
  logic              end_shown;

  edge_det u_vblnk_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (vblnk),
    .rise (vblnk_rise)
  );

  edge_det u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (start_btn),
    .rise (start_rise)
  );

  // Decide the next screen, score and hold count from this cycle's events.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    next_screen_d = next_screen;
    goals_d       = goals;
    misses_d      = misses;
    hold_d        = hold_cnt;
    // Score events count only while the match is both shown and undecided.
    accept        = (screen == SHOOT) && (next_screen == SHOOT);
    end_shown     = (screen == WIN) || (screen == LOSE);

    // A start press is honoured only once START is actually on screen and
    // no other decision is pending; it opens a new match with a clean score.
    if ((screen == START) && (next_screen == START) && start_rise) begin
      next_screen_d = SHOOT;
      goals_d       = '0;
      misses_d      = '0;
    end else if (accept && (goal || miss)) begin
      // A goal wins over a simultaneous miss.
      if (goal) begin
        goals_d = sat_inc(goals);
      end else begin
        misses_d = sat_inc(misses);
      end
      if (int'(goals_d) >= WIN_GOALS) begin
        next_screen_d = WIN;
      end else if (int'(misses_d) >= MAX_MISSES) begin
        next_screen_d = LOSE;
      end
    end

    // Count frame boundaries during which an end screen stays committed.
    // The boundary that first brings the end screen up is not counted, and
    // counting stops once the return to START has been decided.
    if (!end_shown) begin
      hold_d = '0;
    end else if (vblnk_rise && (next_screen == screen)) begin
      if (int'(hold_cnt) + 1 >= END_HOLD_FRAMES) begin
        hold_d        = '0;
        next_screen_d = START;
      end else begin
        hold_d = hold_cnt + 1'b1;
      end
    end
  end

  // Register the decision and commit it to the display on frame boundaries.
  // NOTE: reset is synchronous and overrides everything, so a reset mid-frame
  // returns to START without waiting for vblnk.
  always_ff @(posedge clk) begin
    if (rst) begin
      screen      <= START;
      next_screen <= START;
      goals       <= '0;
      misses      <= '0;
      frame_tick  <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      frame_tick  <= vblnk_rise;
      if (vblnk_rise) begin
        screen <= next_screen;
      end
      next_screen <= next_screen_d;
      goals       <= goals_d;
      misses      <= misses_d;
      hold_cnt    <= hold_d;
    end
  end

endmodule

// File: tb/tb_screen_ctl.sv
// Self-checking bench for screen_ctl: directed match scenarios followed by
// random stimulus, every cycle compared with a screen-level game model.
module tb_screen_ctl;

  localparam int WIN_G    = 3;
  localparam int MAX_M    = 3;
  localparam int HOLD     = 4;
  localparam int FRAME    = 20;  // cycles per frame in directed runs
  localparam int BLANK    = 4;   // trailing vblnk cycles per frame

  localparam int S_START  = 0;
  localparam int S_SHOOT  = 1;
  localparam int S_WIN    = 2;
  localparam int S_LOSE   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblnk;
  logic       start_btn;
  logic       goal;
  logic       miss;
  logic [1:0] screen;
  logic [2:0] goals;
  logic [2:0] misses;
  logic       frame_tick;

  screen_ctl #(
    .WIN_GOALS       (WIN_G),
    .MAX_MISSES      (MAX_M),
    .END_HOLD_FRAMES (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .start_btn  (start_btn),
    .goal       (goal),
    .miss       (miss),
    .screen     (screen),
    .goals      (goals),
    .misses     (misses),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int phase   = 0;
  int n_ticks = 0;
  bit use_phase = 1'b1;

  // Game model: what is on screen, what has been decided, the score,
  // end-screen frames elapsed, and last cycle's vblnk/start levels.
  int m_shown, m_decided, m_goals, m_misses, m_tick, m_held;
  bit m_vb_prev, m_st_prev;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    bit new_frame, pressed;
    int dec;
    if (rst) begin
      m_shown = S_START; m_decided = S_START;
      m_goals = 0; m_misses = 0; m_tick = 0; m_held = 0;
      m_vb_prev = 1'b0; m_st_prev = 1'b0;
      return;
    end
    new_frame = vblnk && !m_vb_prev;
    pressed   = start_btn && !m_st_prev;
    m_vb_prev = vblnk;
    m_st_prev = start_btn;
    dec = m_decided;

    if (m_shown == S_START && m_decided == S_START && pressed) begin
      dec = S_SHOOT;
      m_goals = 0;
      m_misses = 0;
    end else if (m_shown == S_SHOOT && m_decided == S_SHOOT && (goal || miss)) begin
      if (goal) m_goals = (m_goals < 7) ? m_goals + 1 : 7;
      else      m_misses = (m_misses < 7) ? m_misses + 1 : 7;
      if (m_goals >= WIN_G)       dec = S_WIN;
      else if (m_misses >= MAX_M) dec = S_LOSE;
    end

    if (m_shown == S_WIN || m_shown == S_LOSE) begin
      if (new_frame && m_decided == m_shown) begin
        m_held++;
        if (m_held == HOLD) begin
          m_held = 0;
          dec = S_START;
        end
      end
    end else begin
      m_held = 0;
    end

    m_tick = new_frame ? 1 : 0;
    if (new_frame) m_shown = m_decided;
    m_decided = dec;
  endtask

  // One clock: update the model, let the DUT clock, compare on the falling
  // edge, then clear pulses and advance the directed vblnk pattern.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("screen", int'(screen), m_shown);
    check("goals", int'(goals), m_goals);
    check("misses", int'(misses), m_misses);
    check("frame_tick", int'(frame_tick), m_tick);
    if (frame_tick) n_ticks++;
    goal = 1'b0;
    miss = 1'b0;
    phase++;
    if (use_phase) vblnk = ((phase % FRAME) >= (FRAME - BLANK));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until a frame_tick is observed, bounded.
  task automatic until_tick();
    for (int i = 0; i < 4 * FRAME; i++) begin
      step();
      if (frame_tick) return;
    end
    check("tick_timeout", 0, 1);
  endtask

  initial begin
    int t0;
    rst = 1'b1; vblnk = 1'b0; start_btn = 1'b0; goal = 1'b0; miss = 1'b0;
    @(negedge clk);

    // Reset state.
    steps(3);
    check("rst_screen", int'(screen), S_START);
    check("rst_goals", int'(goals), 0);
    check("rst_misses", int'(misses), 0);
    check("rst_tick", int'(frame_tick), 0);
    rst = 1'b0;
    phase = 0;
    vblnk = 1'b0;

    // Three idle frames: three ticks, still START.
    t0 = n_ticks;
    steps(3 * FRAME);
    check("idle_ticks", n_ticks - t0, 3);
    check("idle_screen", int'(screen), S_START);

    // Start pressed mid-frame and held across two frames.
    steps(5);
    start_btn = 1'b1;
    step();
    check("start_pending_screen", int'(screen), S_START);
    until_tick();
    check("start_commit_screen", int'(screen), S_SHOOT);
    goal = 1'b1;
    step();
    until_tick();
    check("held_start_no_clear", int'(goals), 1);
    start_btn = 1'b0;

    // Two more goals win; a fourth before the boundary is ignored.
    for (int i = 0; i < 3; i++) begin
      goal = 1'b1;
      step();
      step();
    end
    check("win_goals_capped", int'(goals), 3);
    check("win_not_yet_shown", int'(screen), S_SHOOT);
    until_tick();
    check("win_shown", int'(screen), S_WIN);

    // Start during the hold is ignored; START returns on the 5th tick.
    start_btn = 1'b1;
    steps(3);
    start_btn = 1'b0;
    for (int i = 1; i <= HOLD + 1; i++) begin
      until_tick();
      if (i == HOLD) check("hold_still_win", int'(screen), S_WIN);
    end
    check("hold_back_to_start", int'(screen), S_START);
    check("hold_goals_kept", int'(goals), 3);

    // New match: goal+miss together, then three misses lose.
    start_btn = 1'b1;
    step();
    check("restart_clear", int'(goals), 0);
    steps(2);
    start_btn = 1'b0;
    until_tick();
    check("restart_shown", int'(screen), S_SHOOT);
    goal = 1'b1;
    miss = 1'b1;
    step();
    check("both_goal", int'(goals), 1);
    check("both_miss_dropped", int'(misses), 0);
    for (int i = 0; i < 3; i++) begin
      miss = 1'b1;
      step();
    end
    check("lose_misses", int'(misses), 3);
    until_tick();
    check("lose_shown", int'(screen), S_LOSE);
    check("lose_goals", int'(goals), 1);
    for (int i = 0; i < HOLD + 1; i++) until_tick();
    check("lose_back_to_start", int'(screen), S_START);

    // Reset in the middle of a match.
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    until_tick();
    goal = 1'b1;
    step();
    steps(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_screen", int'(screen), S_START);
    check("midrst_goals", int'(goals), 0);
    check("midrst_misses", int'(misses), 0);

    // Random traffic, including the pending-decision windows and resets.
    use_phase = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 4) == 0) vblnk = ~vblnk;
      if ($urandom_range(0, 9) == 0) start_btn = ~start_btn;
      goal = ($urandom_range(0, 5) == 0);
      miss = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
